// File: rtl/data_cache_if.sv
// Load/store port bundle between the core memory stage, the data cache and backing memory.
// Latency: wires only; timing is owned by data_cache.
// Backpressure: the cache drives stall toward the core; the memory drives mem_ready toward the cache.
//   slave  : the cache's view (takes requests and memory responses, drives rdata/stall/mem_*)
//   master : the environment's view (core + backing memory)
interface data_cache_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
);
  // core side
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [2:0]            req_size;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  // backing-memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core memory stage.
// Latency: load hit returns rdata in the same cycle; load miss refills a whole line, then replays as a hit.
// Backpressure: stall is high for every miss and every store until the backing memory completes.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus (slave)          core request/response and backing-memory request/response
//   hit_count/miss_count load lookup statistics, present only when DCACHE_STATS_EN is defined
// Optional feature macro: DCACHE_STATS_EN
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 17,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(SETS);
  localparam int TB = ADDR_WIDTH - 2 - WB - IB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

  // storage; only the valid bits need a reset
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];
  logic [TB-1:0]         tag_q  [SETS];
  logic [SETS-1:0]       valid_q;

  // control state
  logic [1:0]            state_q, state_d;
  logic [WB-1:0]         cnt_q, cnt_d;
  logic [TB-1:0]         line_tag_q, line_tag_d;
  logic [IB-1:0]         line_idx_q, line_idx_d;
  logic [WB-1:0]         word_q, word_d;
  logic                  wr_done_q, wr_done_d;
  logic                  refill_done_q, refill_done_d;

  // registered backing-memory outputs, so they stay put while waiting on mem_ready
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;

  // array write strobes
  logic                  refill_we;
  logic                  set_line;
  logic                  store_we;

  // request address split
  logic [TB-1:0]         req_tag;
  logic [IB-1:0]         req_idx;
  logic [WB-1:0]         req_word;
  logic [1:0]            req_byte;

  assign req_tag  = bus.req_addr[ADDR_WIDTH-1 -: TB];
  assign req_idx  = bus.req_addr[2+WB +: IB];
  assign req_word = bus.req_addr[2 +: WB];
  assign req_byte = bus.req_addr[1:0];

  logic                  hit;
  logic                  line_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [WB-1:0]         cnt_inc;

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign line_hit = valid_q[line_idx_q] && (tag_q[line_idx_q] == line_tag_q);
  assign rd_word  = data_q[{req_idx, req_word}];
  assign cnt_inc  = cnt_q + 1'b1;

  // load alignment and extension; misaligned low address bits are ignored
  logic [15:0]           ld_half;
  logic [7:0]            ld_byte;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    ld_half = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_byte = rd_word[{req_byte, 3'b000} +: 8];
    ld_data = rd_word;
    case (bus.req_size[1:0])
      2'b01:   ld_data = bus.req_size[2] ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      2'b10:   ld_data = bus.req_size[2] ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      default: ld_data = rd_word;
    endcase
  end

  // store lane placement: data shifted into its byte lanes, unused lanes zero
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;

  always_comb begin
    lane_be    = 4'hF;
    lane_wdata = bus.req_wdata;
    case (bus.req_size[1:0])
      2'b01: begin
        lane_be    = 4'b0011 << {bus.req_addr[1], 1'b0};
        lane_wdata = {16'h0000, bus.req_wdata[15:0]} << {bus.req_addr[1], 4'b0000};
      end
      2'b10: begin
        lane_be    = 4'b0001 << req_byte;
        lane_wdata = {24'h000000, bus.req_wdata[7:0]} << {req_byte, 3'b000};
      end
      default: begin
        lane_be    = 4'hF;
        lane_wdata = bus.req_wdata;
      end
    endcase
  end

  // core-facing outputs. wr_done_q marks the single cycle after a store completes,
  // in which the still-held store must not be sampled again.
  always_comb begin
    bus.stall = 1'b1;
    bus.rdata = '0;
    if (state_q == S_IDLE) begin
      bus.stall = bus.req_valid && !wr_done_q && (bus.req_we || !hit);
      if (bus.req_valid && !bus.req_we && hit) begin
        bus.rdata = ld_data;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  // next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    line_tag_d    = line_tag_q;
    line_idx_d    = line_idx_q;
    word_d        = word_q;
    wr_done_d     = 1'b0;
    refill_done_d = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    refill_we     = 1'b0;
    set_line      = 1'b0;
    store_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !wr_done_q) begin
          if (bus.req_we) begin
            state_d     = S_WRITE;
            line_tag_d  = req_tag;
            line_idx_d  = req_idx;
            word_d      = req_word;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_be_d    = lane_be;
          end else if (!hit) begin
            state_d     = S_REFILL;
            line_tag_d  = req_tag;
            line_idx_d  = req_idx;
            word_d      = req_word;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {WB{1'b0}}, 2'b00};
            mem_wdata_d = '0;
            mem_be_d    = 4'h0;
          end
        end
      end

      S_REFILL: begin
        if (bus.mem_ready) begin
          refill_we  = 1'b1;
          cnt_d      = cnt_inc;
          mem_addr_d = {line_tag_q, line_idx_q, cnt_inc, 2'b00};
          if (cnt_q == LAST_WORD) begin
            set_line      = 1'b1;
            cnt_d         = '0;
            mem_req_d     = 1'b0;
            refill_done_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        if (bus.mem_ready) begin
          store_we  = line_hit;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wr_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      cnt_q         <= '0;
      line_tag_q    <= '0;
      line_idx_q    <= '0;
      word_q        <= '0;
      wr_done_q     <= 1'b0;
      refill_done_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 4'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_tag_q    <= line_tag_d;
      line_idx_q    <= line_idx_d;
      word_q        <= word_d;
      wr_done_q     <= wr_done_d;
      refill_done_q <= refill_done_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      if (set_line) begin
        valid_q[line_idx_q] <= 1'b1;
      end
    end
  end

  // data and tag arrays; a reset edge suppresses any pending write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_we) begin
        data_q[{line_idx_q, cnt_q}] <= bus.mem_rdata;
      end
      if (set_line) begin
        tag_q[line_idx_q] <= line_tag_q;
      end
      if (store_we) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be_q[i]) begin
            data_q[{line_idx_q, word_q}][8*i +: 8] <= mem_wdata_q[8*i +: 8];
          end
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // one count per fresh load lookup; the replay after a refill and the cycle
  // after a store are not new lookups
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        lookup;

  assign lookup = (state_q == S_IDLE) && bus.req_valid && !bus.req_we &&
                  !wr_done_q && !refill_done_q;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (lookup) begin
      if (hit) begin
        hit_count_d = hit_count_q + 32'd1;
      end else begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a core driver task plus a backing-memory responder
// that raises mem_ready one cycle after each address is presented.
module tb_data_cache;

  logic clk;
  logic rst;

  data_cache_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(17),
    .SETS(64),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // backing memory: preset words, everything else reads as C0DE0000 | address
  logic [31:0] mem_model [int];
  logic [31:0] log_addr [$];
  logic        log_we [$];
  logic [3:0]  log_be [$];
  logic [31:0] log_wdata [$];
  logic        armed;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return 32'hC0DE_0000 | a;
  endfunction

  always @(negedge clk) begin
    logic [31:0] a;
    logic [31:0] w;
    a = {15'b0, bus.mem_addr};
    if (bus.mem_ready) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      armed = bus.mem_req;
    end else if (bus.mem_req && armed) begin
      bus.mem_ready = 1'b1;
      armed = 1'b0;
      log_addr.push_back(a);
      log_we.push_back(bus.mem_we);
      log_be.push_back(bus.mem_be);
      log_wdata.push_back(bus.mem_wdata);
      if (bus.mem_we) begin
        w = mem_read(a);
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
        mem_model[int'(a)] = w;
      end else begin
        bus.mem_rdata = mem_read(a);
      end
    end else begin
      armed = bus.mem_req;
    end
  end

  // results of the most recent access
  logic        first_stall;
  logic        saw_mem_req;
  logic [31:0] got_rdata;
  int          stall_cycles;

  // called at a negedge; holds the request until stall drops, then releases it one edge later
  task automatic access(input logic we, input logic [16:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size);
    int n;
    log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    #1;
    first_stall = bus.stall;
    saw_mem_req = bus.mem_req;
    n = 0;
    while (bus.stall && n < 200) begin
      @(negedge clk); #1;
      saw_mem_req = saw_mem_req | bus.mem_req;
      n++;
    end
    if (n >= 200) check_eq("access_timeout", 32'(n), 32'd0);
    stall_cycles = n;
    got_rdata = bus.rdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    armed         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_size  = 3'b000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    mem_model[32'h10] = 32'h1111_1111;
    mem_model[32'h14] = 32'h2222_2222;
    mem_model[32'h18] = 32'h3333_3333;
    mem_model[32'h1C] = 32'h4444_4444;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
`ifdef DCACHE_STATS_EN
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: cold load miss, four-beat refill, replay hit
    access(1'b0, 17'h10, 32'h0, 3'b000);
    check_eq("t1_stall_now", 32'(first_stall), 32'd1);
    check_eq("t1_rdata", got_rdata, 32'h1111_1111);
    check_eq("t1_beats", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t1_addr%0d", i), log_addr[i], 32'h10 + 32'(4*i));
        check_eq($sformatf("t1_we%0d", i), 32'(log_we[i]), 32'd0);
      end
    end
    check_eq("t1_penalty", 32'(stall_cycles), 32'd9);

    // 2: same-line hit, no memory traffic
    access(1'b0, 17'h14, 32'h0, 3'b000);
    check_eq("t2_stall", 32'(first_stall), 32'd0);
    check_eq("t2_rdata", got_rdata, 32'h2222_2222);
    check_eq("t2_mem_req", 32'(saw_mem_req), 32'd0);
    check_eq("t2_beats", 32'(log_addr.size()), 32'd0);
`ifdef DCACHE_STATS_EN
    check_eq("t2_hit_count", hit_count, 32'd1);
    check_eq("t2_miss_count", miss_count, 32'd1);
`endif
    #1;
    check_eq("idle_stall", 32'(bus.stall), 32'd0);
    check_eq("idle_rdata", bus.rdata, 32'd0);
    @(negedge clk);

    // 3: byte store hit, then signed/unsigned byte and half loads
    access(1'b1, 17'h15, 32'h0000_00AB, 3'b010);
    check_eq("t3_stall_now", 32'(first_stall), 32'd1);
    check_eq("t3_beats", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check_eq("t3_we", 32'(log_we[0]), 32'd1);
      check_eq("t3_be", 32'(log_be[0]), 32'h2);
      check_eq("t3_wdata", log_wdata[0], 32'h0000_AB00);
      check_eq("t3_addr", log_addr[0], 32'h14);
    end
    check_eq("t3_stall_cycles", 32'(stall_cycles), 32'd3);
    access(1'b0, 17'h15, 32'h0, 3'b010);
    check_eq("t3_lb_stall", 32'(first_stall), 32'd0);
    check_eq("t3_lb", got_rdata, 32'hFFFF_FFAB);
    access(1'b0, 17'h15, 32'h0, 3'b110);
    check_eq("t3_lbu", got_rdata, 32'h0000_00AB);
    access(1'b0, 17'h14, 32'h0, 3'b001);
    check_eq("t3_lh", got_rdata, 32'hFFFF_AB22);
    access(1'b0, 17'h16, 32'h0, 3'b101);
    check_eq("t3_lhu_upper", got_rdata, 32'h0000_2222);
    access(1'b0, 17'h17, 32'h0, 3'b000);
    check_eq("t3_lw_misaligned", got_rdata, 32'h2222_AB22);

    // 4: store miss writes through without allocating
    access(1'b1, 17'h400, 32'hDEAD_BEEF, 3'b000);
    check_eq("t4_beats", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check_eq("t4_be", 32'(log_be[0]), 32'hF);
      check_eq("t4_wdata", log_wdata[0], 32'hDEAD_BEEF);
      check_eq("t4_addr", log_addr[0], 32'h400);
    end
    access(1'b0, 17'h400, 32'h0, 3'b000);
    check_eq("t4_load_miss", 32'(first_stall), 32'd1);
    check_eq("t4_rdata", got_rdata, 32'hDEAD_BEEF);

    // 5: conflict eviction in set 1
    access(1'b0, 17'h410, 32'h0, 3'b000);
    check_eq("t5_conflict_miss", 32'(first_stall), 32'd1);
    check_eq("t5_rdata", got_rdata, 32'hC0DE_0410);
    access(1'b0, 17'h10, 32'h0, 3'b000);
    check_eq("t5_evicted_miss", 32'(first_stall), 32'd1);
    check_eq("t5_refetch", got_rdata, 32'h1111_1111);
    access(1'b0, 17'h18, 32'h0, 3'b000);
    check_eq("t5_rehit", 32'(first_stall), 32'd0);
    check_eq("t5_rehit_data", got_rdata, 32'h3333_3333);

    // 6: reset during the second refill beat
    log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 17'h410;
    bus.req_size  = 3'b000;
    n = 0;
    while (log_addr.size() < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("t6_second_beat_seen", 32'(n < 50), 32'd1);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("t6_stall", 32'(bus.stall), 32'd0);
    check_eq("t6_mem_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 17'h10, 32'h0, 3'b000);
    check_eq("t6_load10_miss", 32'(first_stall), 32'd1);
    check_eq("t6_load10_data", got_rdata, 32'h1111_1111);
    access(1'b0, 17'h410, 32'h0, 3'b000);
    check_eq("t6_partial_line_miss", 32'(first_stall), 32'd1);
    check_eq("t6_load410_data", got_rdata, 32'hC0DE_0410);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
